// File: rtl/ycbcr2rgb_if.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_if : pixel bus for the YCbCr-to-RGB converter.
//   ycc_*       : YCbCr pixel stream (valid, line sync, frame sync, Y/Cb/Cr)
//   rgb_*, *_o  : RGB888 pixel stream with matching delayed qualifiers
//   master      : stream source / sink side (drives ycc_*, observes rgb_*)
//   slave       : converter side (observes ycc_*, drives rgb_*)
// ---------------------------------------------------------------------------
interface ycbcr2rgb_if;
   localparam int unsigned PIX_W = 8;

   logic             ycc_valid;
   logic             ycc_hs;
   logic             ycc_vs;
   logic [PIX_W-1:0] y_8b_i;
   logic [PIX_W-1:0] cb_8b_i;
   logic [PIX_W-1:0] cr_8b_i;

   logic [PIX_W-1:0] red_8b_o;
   logic [PIX_W-1:0] green_8b_o;
   logic [PIX_W-1:0] blue_8b_o;
   logic             rgb_valid;
   logic             rgb_hs;
   logic             rgb_vs;

   modport master (
      output ycc_valid, ycc_hs, ycc_vs, y_8b_i, cb_8b_i, cr_8b_i,
      input  red_8b_o, green_8b_o, blue_8b_o, rgb_valid, rgb_hs, rgb_vs
   );

   modport slave (
      input  ycc_valid, ycc_hs, ycc_vs, y_8b_i, cb_8b_i, cr_8b_i,
      output red_8b_o, green_8b_o, blue_8b_o, rgb_valid, rgb_hs, rgb_vs
   );
endinterface

// File: rtl/ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb : 3-stage full-range BT.601 YCbCr -> RGB888 converter.
//   S1 : Y*256 and the four chroma products (shift-add)
//   S2 : rounded channel sums
//   S3 : arithmetic shift, clamp to 0..255, blank when not valid
// Ports:
//   clk        : clock
//   reset_p    : asynchronous active-high reset, clears every register
//   bus        : ycbcr2rgb_if.slave pixel in / pixel out
//   clip_cnt_o : clipped-pixel count of the last frame (YCC_CLIP_CNT_EN only)
// Parameters:
//   LATENCY : pipeline depth, fixed at 3; sizes the qualifier delay lines
//   CNT_W   : clip counter width
// Optional feature macro: YCC_CLIP_CNT_EN enables the per-frame clip counter.
// ---------------------------------------------------------------------------
module ycbcr2rgb #(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_p,
   ycbcr2rgb_if.slave       bus
`ifdef YCC_CLIP_CNT_EN
   ,
   output logic [CNT_W-1:0] clip_cnt_o
`endif
);

   localparam int unsigned ACC_W = 19;
   localparam logic signed [ACC_W-1:0] RND = 19'sd128;

   // Clamp a shifted channel value into 0..255.
   function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
      if (v[ACC_W-1])          return 8'd0;
      else if (v > 19'sd255)   return 8'hFF;
      else                     return v[7:0];
   endfunction

   logic signed [ACC_W-1:0] cb_s, cr_s;
   logic signed [ACC_W-1:0] r_sh, g_sh, b_sh;

   logic signed [ACC_W-1:0] y256_d, y256_q;
   logic signed [ACC_W-1:0] cb88_d, cb88_q, cb454_d, cb454_q;
   logic signed [ACC_W-1:0] cr183_d, cr183_q, cr359_d, cr359_q;
   logic signed [ACC_W-1:0] r_sum_d, r_sum_q, g_sum_d, g_sum_q, b_sum_d, b_sum_q;
   logic [7:0]              red_d, red_q, green_d, green_q, blue_d, blue_q;
   logic [LATENCY-1:0]      vld_d, vld_q, hs_d, hs_q, vs_d, vs_q;

   // Datapath and qualifier delay lines; the top bit of each delay line is
   // the registered output qualifier, the bit below it is the S3 input.
   always_comb begin
      cb_s    = $signed({11'b0, bus.cb_8b_i}) - 19'sd128;
      cr_s    = $signed({11'b0, bus.cr_8b_i}) - 19'sd128;

      y256_d  = $signed({3'b0, bus.y_8b_i, 8'b0});
      cb88_d  = (cb_s <<< 6) + (cb_s <<< 4) + (cb_s <<< 3);
      cb454_d = (cb_s <<< 8) + (cb_s <<< 7) + (cb_s <<< 6) + (cb_s <<< 2) + (cb_s <<< 1);
      cr183_d = (cr_s <<< 7) + (cr_s <<< 5) + (cr_s <<< 4) + (cr_s <<< 2) + (cr_s <<< 1) + cr_s;
      cr359_d = (cr_s <<< 8) + (cr_s <<< 6) + (cr_s <<< 5) + (cr_s <<< 2) + (cr_s <<< 1) + cr_s;

      r_sum_d = y256_q + cr359_q + RND;
      g_sum_d = y256_q - cb88_q - cr183_q + RND;
      b_sum_d = y256_q + cb454_q + RND;

      r_sh    = r_sum_q >>> 8;
      g_sh    = g_sum_q >>> 8;
      b_sh    = b_sum_q >>> 8;

      vld_d   = {vld_q[LATENCY-2:0], bus.ycc_valid};
      hs_d    = {hs_q[LATENCY-2:0],  bus.ycc_hs};
      vs_d    = {vs_q[LATENCY-2:0],  bus.ycc_vs};

      // Blank RGB on beats that were not valid at the input.
      red_d   = vld_q[LATENCY-2] ? clamp8(r_sh) : 8'd0;
      green_d = vld_q[LATENCY-2] ? clamp8(g_sh) : 8'd0;
      blue_d  = vld_q[LATENCY-2] ? clamp8(b_sh) : 8'd0;
   end

   // Pipeline registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         y256_q  <= '0;
         cb88_q  <= '0;
         cb454_q <= '0;
         cr183_q <= '0;
         cr359_q <= '0;
         r_sum_q <= '0;
         g_sum_q <= '0;
         b_sum_q <= '0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         vld_q   <= '0;
         hs_q    <= '0;
         vs_q    <= '0;
      end else begin
         y256_q  <= y256_d;
         cb88_q  <= cb88_d;
         cb454_q <= cb454_d;
         cr183_q <= cr183_d;
         cr359_q <= cr359_d;
         r_sum_q <= r_sum_d;
         g_sum_q <= g_sum_d;
         b_sum_q <= b_sum_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         vld_q   <= vld_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign bus.red_8b_o   = red_q;
   assign bus.green_8b_o = green_q;
   assign bus.blue_8b_o  = blue_q;
   assign bus.rgb_valid  = vld_q[LATENCY-1];
   assign bus.rgb_hs     = hs_q[LATENCY-1];
   assign bus.rgb_vs     = vs_q[LATENCY-1];

`ifdef YCC_CLIP_CNT_EN
   // True when a shifted channel value lies outside 0..255.
   function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] || (v > 19'sd255);
   endfunction

   logic             beat_clip, vs_rise;
   logic [CNT_W-1:0] run_inc;
   logic [CNT_W-1:0] run_cnt_d, run_cnt_q, clip_cnt_d, clip_cnt_q;

   // Saturating per-frame clip counter, latched on the S3 vs rising edge.
   always_comb begin
      beat_clip  = vld_q[LATENCY-2] &
                   (out_of_range(r_sh) | out_of_range(g_sh) | out_of_range(b_sh));
      vs_rise    = vs_q[LATENCY-2] & ~vs_q[LATENCY-1];
      run_inc    = (beat_clip && (run_cnt_q != '1)) ? run_cnt_q + CNT_W'(1) : run_cnt_q;
      run_cnt_d  = run_inc;
      clip_cnt_d = clip_cnt_q;
      if (vs_rise) begin
         clip_cnt_d = run_inc;
         run_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         run_cnt_q  <= '0;
         clip_cnt_q <= '0;
      end else begin
         run_cnt_q  <= run_cnt_d;
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign clip_cnt_o = clip_cnt_q;
`else
   // CNT_W only sizes the clip counter; nothing to build without it.
   if (CNT_W == 0) begin : g_no_clip_cnt
   end
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// tb_ycbcr2rgb : self-checking bench for ycbcr2rgb.
// Every negedge the outputs are compared with the expectation recorded for
// the inputs driven three negedges earlier, then new inputs are driven.
// Build with +define+YCC_CLIP_CNT_EN to also exercise the clip counter.
// ---------------------------------------------------------------------------
module tb_ycbcr2rgb;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic       v;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   typedef struct {
      logic [7:0] y, cb, cr;
      logic [7:0] r, g, b;
   } vec_t;

   logic clk = 1'b0;
   logic reset_p;
   int   total = 0;
   int   bad   = 0;
   int   nstep = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   ycbcr2rgb_if bus_if ();

`ifdef YCC_CLIP_CNT_EN
   logic [CNT_W-1:0] clip_cnt;
`endif

   ycbcr2rgb #(.LATENCY(3), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .bus        (bus_if)
`ifdef YCC_CLIP_CNT_EN
      ,
      .clip_cnt_o (clip_cnt)
`endif
   );

   function automatic int clamp255(input int v);
      if (v < 0)   return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // Reference conversion straight from the BT.601 full-range equations.
   function automatic exp_t model(input logic v, input logic hs, input logic vs,
                                  input logic [7:0] y, input logic [7:0] cb,
                                  input logic [7:0] cr);
      exp_t e;
      int yy, cbp, crp;
      yy  = int'(y);
      cbp = int'(cb) - 128;
      crp = int'(cr) - 128;
      e.v  = v;
      e.hs = hs;
      e.vs = vs;
      e.r  = v ? 8'(clamp255((256*yy + 359*crp + 128) >>> 8)) : 8'd0;
      e.g  = v ? 8'(clamp255((256*yy - 88*cbp - 183*crp + 128) >>> 8)) : 8'd0;
      e.b  = v ? 8'(clamp255((256*yy + 454*cbp + 128) >>> 8)) : 8'd0;
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e = '0;
      return e;
   endfunction

   // One cycle: check outputs against the expectation from 3 cycles back,
   // then drive new inputs and queue what they must produce.
   task automatic step(input logic v, input logic hs, input logic vs,
                       input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                       input exp_t e);
      exp_t got, want;
      @(negedge clk);
      got  = {bus_if.rgb_valid, bus_if.rgb_hs, bus_if.rgb_vs,
              bus_if.red_8b_o, bus_if.green_8b_o, bus_if.blue_8b_o};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL stream step=%0d got v/hs/vs=%b%b%b rgb=%0d,%0d,%0d want v/hs/vs=%b%b%b rgb=%0d,%0d,%0d",
                  nstep, got.v, got.hs, got.vs, got.r, got.g, got.b,
                  want.v, want.hs, want.vs, want.r, want.g, want.b);
      end
      nstep++;
      bus_if.ycc_valid = v;
      bus_if.ycc_hs    = hs;
      bus_if.ycc_vs    = vs;
      bus_if.y_8b_i    = y;
      bus_if.cb_8b_i   = cb;
      bus_if.cr_8b_i   = cr;
      exp_q.push_back(e);
   endtask

   task automatic step_m(input logic v, input logic hs, input logic vs,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
      step(v, hs, vs, y, cb, cr, model(v, hs, vs, y, cb, cr));
   endtask

   task automatic step_rand(input logic v, input logic hs, input logic vs);
      step_m(v, hs, vs, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic check_zero(input string name);
      logic [26:0] all;
      all = {bus_if.rgb_valid, bus_if.rgb_hs, bus_if.rgb_vs,
             bus_if.red_8b_o, bus_if.green_8b_o, bus_if.blue_8b_o};
      total++;
      if (all !== '0) begin
         bad++;
         $display("FAIL %s outputs=%h want 0", name, all);
      end
`ifdef YCC_CLIP_CNT_EN
      total++;
      if (clip_cnt !== '0) begin
         bad++;
         $display("FAIL %s clip_cnt=%0d want 0", name, clip_cnt);
      end
`endif
   endtask

   task automatic drive_idle();
      bus_if.ycc_valid = 1'b0;
      bus_if.ycc_hs    = 1'b0;
      bus_if.ycc_vs    = 1'b0;
      bus_if.y_8b_i    = '0;
      bus_if.cb_8b_i   = '0;
      bus_if.cr_8b_i   = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset_p = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_zero("reset_state");
      @(negedge clk);
      reset_p = 1'b0;
      exp_q = '{zero_exp(), zero_exp(), zero_exp()};
   endtask

`ifdef YCC_CLIP_CNT_EN
   task automatic check_clip(input string name, input logic [CNT_W-1:0] want);
      total++;
      if (clip_cnt !== want) begin
         bad++;
         $display("FAIL %s clip_cnt=%0d want %0d", name, clip_cnt, want);
      end
   endtask
`endif

   initial begin
      vec_t vecs[7];
      vecs[0] = '{y:8'd128, cb:8'd128, cr:8'd128, r:8'd128, g:8'd128, b:8'd128};
      vecs[1] = '{y:8'd76,  cb:8'd85,  cr:8'd255, r:8'd254, g:8'd0,   b:8'd0};
      vecs[2] = '{y:8'd255, cb:8'd128, cr:8'd255, r:8'd255, g:8'd164, b:8'd255};
      vecs[3] = '{y:8'd0,   cb:8'd0,   cr:8'd0,   r:8'd0,   g:8'd136, b:8'd0};
      vecs[4] = '{y:8'd255, cb:8'd128, cr:8'd128, r:8'd255, g:8'd255, b:8'd255};
      vecs[5] = '{y:8'd0,   cb:8'd128, cr:8'd128, r:8'd0,   g:8'd0,   b:8'd0};
      vecs[6] = '{y:8'd0,   cb:8'd255, cr:8'd128, r:8'd0,   g:8'd0,   b:8'd225};

      reset_p = 1'b0;
      drive_idle();
      #2;
      do_reset();

      // Known vectors, each as an isolated one-cycle valid pulse.
      for (int i = 0; i < 7; i++) begin
         exp_t e;
         e = '{v:1'b1, hs:1'b0, vs:1'b0, r:vecs[i].r, g:vecs[i].g, b:vecs[i].b};
         step(1'b1, 1'b0, 1'b0, vecs[i].y, vecs[i].cb, vecs[i].cr, e);
         repeat (3) step_rand(1'b0, 1'b0, 1'b0);
      end

      // Same vectors back to back.
      for (int i = 0; i < 7; i++) begin
         exp_t e;
         e = '{v:1'b1, hs:1'b0, vs:1'b0, r:vecs[i].r, g:vecs[i].g, b:vecs[i].b};
         step(1'b1, 1'b0, 1'b0, vecs[i].y, vecs[i].cb, vecs[i].cr, e);
      end
      repeat (3) step_rand(1'b0, 1'b0, 1'b0);

      // hs/vs shapes with valid low: 44-cycle hs per line, vs over 5 lines.
      for (int line = 0; line < 7; line++)
         for (int c = 0; c < 60; c++)
            step_rand(1'b0, c < 44, (line >= 1) && (line <= 5));

      // Full 1920-pixel line with valid held high.
      for (int i = 0; i < 1920; i++) step_rand(1'b1, 1'b0, 1'b0);
      repeat (3) step_rand(1'b0, 1'b0, 1'b0);

      // Random valid gaps and syncs.
      for (int i = 0; i < 2000; i++)
         step_rand(($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 15) == 0));

      // Asynchronous reset with pixels in flight.
      repeat (3) step_m(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
      @(posedge clk);
      #1;
      total++;
      if (bus_if.rgb_valid !== 1'b1 || bus_if.red_8b_o !== 8'd128) begin
         bad++;
         $display("FAIL midrst_pre valid=%b r=%0d want 1/128", bus_if.rgb_valid, bus_if.red_8b_o);
      end
      #1;
      drive_idle();
      reset_p = 1'b1;
      #1;
      check_zero("midrst_async");
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset_p = 1'b0;
      exp_q = '{zero_exp(), zero_exp(), zero_exp()};
      step_m(1'b1, 1'b0, 1'b0, 8'd76, 8'd85, 8'd255);
      repeat (5) step_rand(1'b0, 1'b0, 1'b0);

`ifdef YCC_CLIP_CNT_EN
      // Frame of 10 pixels, 4 of them clipping.
      do_reset();
      step_rand(1'b0, 1'b0, 1'b1);
      step_rand(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0 && i < 10) step_m(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
         else                      step_m(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
      end
      step_rand(1'b0, 1'b0, 1'b1);
      repeat (4) step_rand(1'b0, 1'b0, 1'b0);
      check_clip("clip_frame", CNT_W'(4));
      repeat (5) step_rand(1'b0, 1'b0, 1'b0);
      check_clip("clip_hold", CNT_W'(4));

      // Saturation.
      for (int i = 0; i < (1 << CNT_W) + 5; i++)
         step_m(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      step_rand(1'b0, 1'b0, 1'b1);
      repeat (4) step_rand(1'b0, 1'b0, 1'b0);
      check_clip("clip_sat", '1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
